// File: rtl/gray_disp_pkg.sv
// Shared types and helpers for the Gray-code decoder / decimal display block.
package gray_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } bcd_state_t;

    // 7-segment pattern for one BCD nibble, bit 0 = a ... bit 6 = g, active high.
    // Nibbles above 9 cannot come out of the converter; they map to blank.
    function automatic logic [6:0] seg7_of(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Gray to binary for a word of w bits (w <= 32): bin[i] = ^gray[w-1:i].
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] mask;
        logic [31:0] gm;
        logic [31:0] b;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        gm   = g & mask;
        b    = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH shifts per word.
module bin2bcd_seq
    import gray_disp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int SRW  = WIDTH + 4*DIGITS;
    localparam int CNTW = $clog2(WIDTH + 1);

    bcd_state_t        state_q;
    logic [SRW-1:0]    sr_q;
    logic [SRW-1:0]    sr_d;
    logic [CNTW-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;

    // One dabble step: add 3 to every BCD nibble >= 5, then shift the whole register left.
    always_comb begin
        logic [SRW-1:0] adj;
        adj = sr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[WIDTH+4*d +: 4] >= 4'd5)
                adj[WIDTH+4*d +: 4] = adj[WIDTH+4*d +: 4] + 4'd3;
        end
        sr_d = {adj[SRW-2:0], 1'b0};
    end

    // Conversion FSM; a start seen in LOAD chains straight into the next conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sr_q    <= {{(4*DIGITS){1'b0}}, bin_i};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        sr_q    <= {{(4*DIGITS){1'b0}}, bin_i};
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = sr_q[SRW-1 -: 4*DIGITS];

endmodule

// File: rtl/gray_decode_display.sv
// Gray input -> debounced binary on LEDs -> decimal on static 7-segment digits.
module gray_decode_display
    import gray_disp_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int DIGITS        = 2,
    parameter int STABLE_CYCLES = 4,
    parameter bit SEG_ACT_LOW   = 1'b0,
    parameter bit BLANK_LZ      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      gray_i,
    output logic [WIDTH-1:0]      led_o,
    output logic [7*DIGITS-1:0]   seg_o,
    output logic                  busy_o,
    output logic                  update_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    // The display must be able to show the largest binary value.
    if (longint'(10) ** DIGITS <= (longint'(1) << WIDTH) - 1) begin : g_digits_too_few
        $error("gray_decode_display: DIGITS too small for WIDTH");
    end

    logic [1:0]              rsync_q;
    logic                    rst_int_n;
    logic [WIDTH-1:0]        s1_q, s2_q, acc_q, led_q, pval_q;
    logic [CW-1:0]           cnt_q;
    logic                    pend_q, upd_q;
    logic [7*DIGITS-1:0]     seg_q;
    logic                    accept, start;
    logic [WIDTH-1:0]        bin_s;
    logic                    bcd_busy, bcd_done;
    logic [4*DIGITS-1:0]     bcd;

    // Segment formatting: LUT, optional leading-zero blanking, then polarity.
    function automatic logic [7*DIGITS-1:0] fmt(input logic [4*DIGITS-1:0] b);
        logic [7*DIGITS-1:0] s;
        logic                lead;
        s    = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            s[7*k +: 7] = seg7_of(b[4*k +: 4]);
            if (BLANK_LZ && k > 0 && lead && b[4*k +: 4] == 4'd0)
                s[7*k +: 7] = 7'h00;
            else
                lead = 1'b0;
        end
        if (SEG_ACT_LOW)
            s = ~s;
        return s;
    endfunction

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsync_q <= 2'b00;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end
    assign rst_int_n = rsync_q[1];

    // A new word is taken once the synced value has held STABLE_CYCLES and differs from the last one.
    assign accept = (cnt_q == CW'(STABLE_CYCLES)) && (s2_q != acc_q);
    assign bin_s  = WIDTH'(gray2bin(32'(s2_q), WIDTH));
    // The converter can take a word while idle or in its final (LOAD) cycle.
    assign start  = pend_q && (!bcd_busy || bcd_done);

    // Synchroniser, stability filter, LED register and single-entry pending word.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            led_q  <= '0;
            pend_q <= 1'b0;
            pval_q <= '0;
        end else begin
            s1_q <= gray_i;
            s2_q <= s1_q;
            if (s1_q != s2_q)
                cnt_q <= '0;
            else if (cnt_q != CW'(STABLE_CYCLES))
                cnt_q <= cnt_q + CW'(1);
            if (accept) begin
                acc_q  <= s2_q;
                led_q  <= bin_s;
                pend_q <= 1'b1;
                pval_q <= bin_s;
            end else if (start) begin
                pend_q <= 1'b0;
            end
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .start_i (start),
        .bin_i   (pval_q),
        .busy_o  (bcd_busy),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    // Display register loads when the converter reports a finished word.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            seg_q <= fmt('0);
            upd_q <= 1'b0;
        end else begin
            upd_q <= bcd_done;
            if (bcd_done)
                seg_q <= fmt(bcd);
        end
    end

    assign led_o    = led_q;
    assign seg_o    = seg_q;
    assign busy_o   = pend_q | bcd_busy;
    assign update_o = upd_q;

endmodule
